led_pwm_sequencer: RTL and testbench

Parametrised LED bank driver that replaces the hand-instantiated per-LED PWM chain and its fixed-offset chase counter in the top level. It drives CHANNELS LED outputs from one shared PWM counter and runs one of four animation modes: off, chase, breathe or static mask. Mode and settings are written through a simple byte write port fed from the UART-to-bus interface. Duty updates are applied only at PWM period boundaries, so there are no glitch pulses.

---
 rtl/led_pwm_sequencer.sv | 155 +++++++++++++++
 tb/tb_led_pwm_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_sequencer.sv
// LED bank driver: one shared PWM counter, per-channel shadow duties swapped at
// period boundaries, and an off / chase / breathe / static animation engine.
module led_pwm_sequencer #(
  parameter int CHANNELS  = 8,
  parameter int PWM_BITS  = 8,
  parameter int RAMP_BITS = 5,
  parameter int STEP_DIV  = 10000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [1:0]          i_wr_addr,
  input  logic [7:0]          i_wr_data,
  output logic [CHANNELS-1:0] o_led,
  output logic                o_step
);

  localparam int                   DIV_W      = $clog2(STEP_DIV);
  localparam int                   SHIFT      = PWM_BITS - RAMP_BITS;
  localparam logic [7:0]           PHASE_RST  = 8'd5;
  localparam logic [7:0]           BRIGHT_RST = 8'h10;
  localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(STEP_DIV - 1);
  localparam logic [RAMP_BITS-1:0] LVL_MAX    = '1;
  localparam logic [PWM_BITS-1:0]  PCNT_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_e;

  mode_e                mode_q, mode_d;
  logic [RAMP_BITS-1:0] phase_q, phase_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d;
  logic [CHANNELS-1:0]  mask_q, mask_d;
  logic [DIV_W-1:0]     presc_q, presc_d;
  logic [RAMP_BITS-1:0] lvl_q, lvl_d;
  logic                 dir_q, dir_d;
  logic [PWM_BITS-1:0]  pcnt_q, pcnt_d;
  logic [CHANNELS-1:0]  led_q, led_d;
  logic                 step_q, step_d;

  logic                 tick;
  logic                 mode_wr;
  logic [RAMP_BITS-1:0] lvl_up;
  logic [RAMP_BITS-1:0] lvl_dn;

  assign tick    = (presc_q == DIV_LAST);
  assign mode_wr = i_wr_en && (i_wr_addr == 2'd0);
  assign lvl_up  = lvl_q + 1'b1;
  assign lvl_dn  = lvl_q - 1'b1;

  always_comb begin
    mode_d   = mode_q;
    phase_d  = phase_q;
    bright_d = bright_q;
    mask_d   = mask_q;
    lvl_d    = lvl_q;
    dir_d    = dir_q;
    pcnt_d   = pcnt_q + 1'b1;
    // A mode write restarts the animation and suppresses a coincident tick.
    step_d   = tick && !mode_wr;
    presc_d  = (mode_wr || tick) ? '0 : presc_q + 1'b1;

    if (mode_wr) begin
      lvl_d = '0;
      dir_d = 1'b1;
    end else if (tick) begin
      case (mode_q)
        MODE_CHASE: lvl_d = lvl_dn;
        MODE_BREATHE: begin
          if (dir_q) begin
            lvl_d = lvl_up;
            if (lvl_up == LVL_MAX) dir_d = 1'b0;
          end else begin
            lvl_d = lvl_dn;
            if (lvl_dn == '0) dir_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (i_wr_en) begin
      case (i_wr_addr)
        2'd0:    mode_d   = mode_e'(i_wr_data[1:0]);
        2'd1:    phase_d  = i_wr_data[RAMP_BITS-1:0];
        2'd2:    bright_d = i_wr_data[PWM_BITS-1:0];
        default: mask_d   = i_wr_data[CHANNELS-1:0];
      endcase
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [RAMP_BITS-1:0] K = RAMP_BITS'(gi);

    logic [RAMP_BITS-1:0] offset;
    logic [RAMP_BITS-1:0] chase_lvl;
    logic [PWM_BITS-1:0]  target;
    logic [PWM_BITS-1:0]  shadow_q, shadow_d;

    // Offset and difference both wrap in RAMP_BITS, giving the modular chase.
    assign offset    = K * phase_q;
    assign chase_lvl = lvl_q - offset;

    always_comb begin
      target = '0;
      case (mode_q)
        MODE_CHASE:   target = PWM_BITS'(chase_lvl) << SHIFT;
        MODE_BREATHE: target = PWM_BITS'(lvl_q) << SHIFT;
        MODE_STATIC:  target = mask_q[gi] ? bright_q : '0;
        default:      target = '0;
      endcase
    end

    assign shadow_d   = (pcnt_q == PCNT_MAX) ? target : shadow_q;
    assign led_d[gi]  = (pcnt_q < shadow_q);

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) shadow_q <= '0;
      else          shadow_q <= shadow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q   <= MODE_CHASE;
      phase_q  <= PHASE_RST[RAMP_BITS-1:0];
      bright_q <= BRIGHT_RST[PWM_BITS-1:0];
      mask_q   <= '0;
      presc_q  <= '0;
      lvl_q    <= '0;
      dir_q    <= 1'b1;
      pcnt_q   <= '0;
      led_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      bright_q <= bright_d;
      mask_q   <= mask_d;
      presc_q  <= presc_d;
      lvl_q    <= lvl_d;
      dir_q    <= dir_d;
      pcnt_q   <= pcnt_d;
      led_q    <= led_d;
      step_q   <= step_d;
    end
  end

  assign o_led  = led_q;
  assign o_step = step_q;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Bench for led_pwm_sequencer: directed scenario tasks plus a randomized run
// compared against a step-count based reference model.
module tb_led_pwm_sequencer;

  localparam int CH    = 4;
  localparam int PB    = 4;
  localparam int RB    = 2;
  localparam int SD    = 4;
  localparam int PER   = 1 << PB;
  localparam int LV    = 1 << RB;
  localparam int SCALE = 1 << (PB - RB);

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [7:0]    wr_data = 8'd0;
  logic [CH-1:0] led;
  logic          step;

  led_pwm_sequencer #(
    .CHANNELS (CH),
    .PWM_BITS (PB),
    .RAMP_BITS(RB),
    .STEP_DIV (SD)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .o_led    (led),
    .o_step   (step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: settings, clocks since release, prescaler phase and the
  // number of animation steps taken since the last mode write.
  int            m_mode, m_phase, m_bright, m_mask;
  int            m_t, m_presc, m_steps;
  int            m_shadow [CH];
  logic [CH-1:0] exp_led = '0;
  logic          exp_step = 1'b0;
  int            hc [CH];

  function automatic int target_duty(input int k);
    int lvl;
    int p;
    lvl = 0;
    p   = 0;
    case (m_mode)
      1: begin
        lvl = (LV - (m_steps % LV)) % LV;
        return ((((lvl - k * m_phase) % LV) + LV) % LV) * SCALE;
      end
      2: begin
        p   = m_steps % (2 * (LV - 1));
        lvl = (p < LV) ? p : 2 * (LV - 1) - p;
        return lvl * SCALE;
      end
      3: return ((m_mask >> k) & 1) != 0 ? m_bright : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic en, input logic [1:0] a,
                            input logic [7:0] d);
    bit tck;
    bit mw;
    if (!r) begin
      m_mode = 1; m_phase = 5 % LV; m_bright = 16 % PER; m_mask = 0;
      m_t = 0; m_presc = 0; m_steps = 0;
      for (int k = 0; k < CH; k++) m_shadow[k] = 0;
      exp_led  = '0;
      exp_step = 1'b0;
    end else begin
      tck = (m_presc == SD - 1);
      mw  = en && (a == 2'd0);
      for (int k = 0; k < CH; k++) exp_led[k] = ((m_t % PER) < m_shadow[k]);
      exp_step = tck && !mw;
      if ((m_t % PER) == PER - 1)
        for (int k = 0; k < CH; k++) m_shadow[k] = target_duty(k);
      m_t++;
      if (mw) begin
        m_presc = 0;
        m_steps = 0;
      end else begin
        m_presc = tck ? 0 : m_presc + 1;
        if (tck && (m_mode == 1 || m_mode == 2)) m_steps++;
      end
      if (en) begin
        case (a)
          2'd0:    m_mode   = int'(d) % 4;
          2'd1:    m_phase  = int'(d) % LV;
          2'd2:    m_bright = int'(d) % PER;
          default: m_mask   = int'(d) % (1 << CH);
        endcase
      end
    end
  endtask

  task automatic drive_cycle(input logic en, input logic [1:0] a, input logic [7:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
    model_edge(rst_n, en, a, d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 2'd0, 8'd0);
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    drive_cycle(1'b1, a, d);
  endtask

  task automatic idle_until(input int ph);
    for (int i = 0; i < PER && (m_t % PER) != ph; i++) idle();
  endtask

  // Advance past the next shadow load so the next cycle starts a fresh period.
  task automatic next_period();
    idle();
    for (int i = 0; i < PER && (m_t % PER) != 0; i++) idle();
  endtask

  task automatic measure_period();
    for (int k = 0; k < CH; k++) hc[k] = 0;
    for (int i = 0; i < PER; i++) begin
      idle();
      for (int k = 0; k < CH; k++) if (led[k]) hc[k]++;
    end
  endtask

  task automatic test_reset();
    int first;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (led !== 4'b0000) begin
        errors++;
        $display("FAIL reset_led cycle %0d got %b want 0000", i, led);
      end
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL reset_step cycle %0d got %b want 0", i, step);
      end
    end
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= PER; i++) begin
      idle();
      checks++;
      if (led !== 4'b0000) begin
        errors++;
        $display("FAIL first_period_led cycle %0d got %b want 0000", i, led);
      end
      if (step === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != SD) begin
      errors++;
      $display("FAIL first_step got cycle %0d want %0d", first, SD);
    end
    $display("reset: first step at cycle %0d", first);
  endtask

  task automatic test_chase();
    int want [CH];
    want = '{12, 8, 4, 0};
    write(2'd1, 8'd1);
    idle_until(9);
    write(2'd0, 8'd1);
    repeat (6) idle();
    measure_period();
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (hc[k] != want[k]) begin
        errors++;
        $display("FAIL chase_ch%0d got %0d want %0d", k, hc[k], want[k]);
      end
    end
    $display("chase: counts %0d %0d %0d %0d", hc[0], hc[1], hc[2], hc[3]);
  endtask

  task automatic test_breathe();
    int want [8];
    want = '{0, 4, 8, 12, 8, 4, 0, 4};
    for (int s = 0; s < 8; s++) begin
      idle_until(((13 - 4 * s) % PER + PER) % PER);
      write(2'd0, 8'd2);
      repeat (4 * s + 2) idle();
      measure_period();
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (hc[k] != want[s]) begin
          errors++;
          $display("FAIL breathe_step%0d_ch%0d got %0d want %0d", s, k, hc[k], want[s]);
        end
      end
      $display("breathe: step %0d counts %0d %0d %0d %0d", s, hc[0], hc[1], hc[2], hc[3]);
    end
  endtask

  task automatic test_static();
    int want [CH];
    write(2'd3, 8'b0101);
    write(2'd2, 8'd8);
    write(2'd0, 8'd3);
    next_period();
    measure_period();
    want = '{8, 0, 8, 0};
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (hc[k] != want[k]) begin
        errors++;
        $display("FAIL static8_ch%0d got %0d want %0d", k, hc[k], want[k]);
      end
    end
    $display("static: bright 8 counts %0d %0d %0d %0d", hc[0], hc[1], hc[2], hc[3]);
    write(2'd2, 8'd15);
    next_period();
    measure_period();
    want = '{15, 0, 15, 0};
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (hc[k] != want[k]) begin
        errors++;
        $display("FAIL static15_ch%0d got %0d want %0d", k, hc[k], want[k]);
      end
    end
    $display("static: bright 15 counts %0d %0d %0d %0d", hc[0], hc[1], hc[2], hc[3]);
  endtask

  task automatic test_glitch_free();
    int cur [CH];
    write(2'd2, 8'd8);
    next_period();
    for (int k = 0; k < CH; k++) cur[k] = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == 5) write(2'd2, 8'd2);
      else        idle();
      for (int k = 0; k < CH; k++) if (led[k]) cur[k]++;
    end
    measure_period();
    for (int k = 0; k < CH; k += 2) begin
      checks++;
      if (cur[k] != 8) begin
        errors++;
        $display("FAIL glitch_current_ch%0d got %0d want 8", k, cur[k]);
      end
      checks++;
      if (hc[k] != 2) begin
        errors++;
        $display("FAIL glitch_next_ch%0d got %0d want 2", k, hc[k]);
      end
    end
    $display("glitch: current %0d/%0d next %0d/%0d", cur[0], cur[2], hc[0], hc[2]);
  endtask

  task automatic test_collision();
    int first;
    int want [CH];
    want = '{0, 12, 8, 4};
    idle_until(8);
    write(2'd0, 8'd1);
    repeat (3) idle();
    write(2'd0, 8'd1);
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL collision_step_now got %b want 0", step);
    end
    first = -1;
    for (int k = 0; k < CH; k++) hc[k] = 0;
    for (int i = 1; i <= PER + 3; i++) begin
      idle();
      if (step === 1'b1 && first < 0) first = i;
      if (i >= 4) for (int k = 0; k < CH; k++) if (led[k]) hc[k]++;
    end
    checks++;
    if (first != SD) begin
      errors++;
      $display("FAIL collision_next_step got cycle %0d want %0d", first, SD);
    end
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (hc[k] != want[k]) begin
        errors++;
        $display("FAIL collision_lvl0_ch%0d got %0d want %0d", k, hc[k], want[k]);
      end
    end
    $display("collision: next step at %0d counts %0d %0d %0d %0d",
             first, hc[0], hc[1], hc[2], hc[3]);
  endtask

  task automatic test_random();
    int r;
    int bad;
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (n == 300 || n == 301) begin
        rst_n = 1'b0;
        idle();
      end else begin
        rst_n = 1'b1;
        if (r < 12) write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        else        idle();
      end
      checks++;
      if (led !== exp_led) begin
        errors++;
        bad++;
        $display("FAIL random_led cycle %0d got %b want %b", n, led, exp_led);
      end
      checks++;
      if (step !== exp_step) begin
        errors++;
        bad++;
        $display("FAIL random_step cycle %0d got %b want %b", n, step, exp_step);
      end
    end
    rst_n = 1'b1;
    $display("random: 600 cycles, %0d bad", bad);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_chase();
    test_breathe();
    test_static();
    test_glitch_free();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
